// File: rtl/dffsr_pipe_if.sv
// Bus bundle for dffsr_pipe: stage-0 controls and data in, pipeline tail and
// occupancy out. The pipeline has no backpressure; EN is a plain advance strobe,
// VALID_IN/VALID_OUT are qualifiers, and nothing waits on a ready signal.
interface dffsr_pipe_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
);
   logic                         EN;
   logic                         VALID_IN;
   logic [WIDTH-1:0]             D;
   logic [WIDTH-1:0]             SET;
   logic [WIDTH-1:0]             CLR;
   logic [WIDTH-1:0]             Q;
   logic                         VALID_OUT;
   logic [$clog2(DEPTH+1)-1:0]   CNT;

   modport master (
      output EN, VALID_IN, D, SET, CLR,
      input  Q, VALID_OUT, CNT
   );

   modport slave (
      input  EN, VALID_IN, D, SET, CLR,
      output Q, VALID_OUT, CNT
   );
endinterface

// File: rtl/dffsr_pipe.sv
// Multi-stage register pipeline. Stage 0 is a set/clear flop word whose masks
// act every cycle, even while stalled; later stages are a plain stallable delay
// line of data plus valid. CNT tracks how many stages currently hold valid data.
module dffsr_pipe #(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 3,
   parameter bit               CLR_PRIO = 1'b1,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic          CLK,
   input  logic          RST,
   dffsr_pipe_if.slave   bus
);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] s_q [DEPTH];
   logic [DEPTH-1:0] v_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [WIDTH-1:0] base_d;
   logic [WIDTH-1:0] s0_d;
   logic             cnt_inc;
   logic             cnt_dec;

   // Stage-0 next word: pick new data or hold, then apply the SET/CLR masks.
   always_comb begin
      base_d = bus.EN ? bus.D : s_q[0];
      s0_d   = base_d;
      if (CLR_PRIO) begin
         s0_d = (base_d | bus.SET) & ~bus.CLR;
      end else begin
         s0_d = (base_d & ~bus.CLR) | bus.SET;
      end
   end

   // Occupancy: +1 when a valid word enters, -1 when a valid word leaves the tail.
   always_comb begin
      cnt_inc = bus.EN & bus.VALID_IN;
      cnt_dec = bus.EN & v_q[DEPTH-1];
      cnt_d   = cnt_q;
      case ({cnt_inc, cnt_dec})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Stage 0 data always updates (masks apply during stalls); its valid moves only on EN.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s_q[0] <= RST_VAL;
         v_q[0] <= 1'b0;
      end else begin
         s_q[0] <= s0_d;
         if (bus.EN) begin
            v_q[0] <= bus.VALID_IN;
         end
      end
   end

   // Delay line for stages 1..DEPTH-1; shifts only on EN, untouched by the masks.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 1; k < DEPTH; k++) begin
            s_q[k] <= RST_VAL;
            v_q[k] <= 1'b0;
         end
      end else if (bus.EN) begin
         for (int k = 1; k < DEPTH; k++) begin
            s_q[k] <= s_q[k-1];
            v_q[k] <= v_q[k-1];
         end
      end
   end

   // Occupancy counter register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.Q         = s_q[DEPTH-1];
   assign bus.VALID_OUT = v_q[DEPTH-1];
   assign bus.CNT       = cnt_q;
endmodule

// File: tb/tb_dffsr_pipe.sv
// Directed bench for dffsr_pipe: a default instance, a SET-priority instance and
// a single-stage instance all share one stimulus set.
module tb_dffsr_pipe;
   logic       clk;
   logic       rst;
   logic       en;
   logic       vin;
   logic [7:0] d;
   logic [7:0] set_m;
   logic [7:0] clr_m;

   int n_checks;
   int n_fail;
   bit mon_en;
   logic [2:0] ref_v;

   dffsr_pipe_if #(.WIDTH(8), .DEPTH(3)) if0 ();
   dffsr_pipe_if #(.WIDTH(8), .DEPTH(3)) if1 ();
   dffsr_pipe_if #(.WIDTH(8), .DEPTH(1)) if2 ();

   assign if0.EN = en;  assign if0.VALID_IN = vin;  assign if0.D = d;
   assign if0.SET = set_m;  assign if0.CLR = clr_m;
   assign if1.EN = en;  assign if1.VALID_IN = vin;  assign if1.D = d;
   assign if1.SET = set_m;  assign if1.CLR = clr_m;
   assign if2.EN = en;  assign if2.VALID_IN = vin;  assign if2.D = d;
   assign if2.SET = set_m;  assign if2.CLR = clr_m;

   dffsr_pipe #(.WIDTH(8), .DEPTH(3), .CLR_PRIO(1'b1), .RST_VAL(8'h00)) u_main (
      .CLK(clk), .RST(rst), .bus(if0.slave));
   dffsr_pipe #(.WIDTH(8), .DEPTH(3), .CLR_PRIO(1'b0), .RST_VAL(8'h00)) u_setp (
      .CLK(clk), .RST(rst), .bus(if1.slave));
   dffsr_pipe #(.WIDTH(8), .DEPTH(1), .CLR_PRIO(1'b1), .RST_VAL(8'h00)) u_d1 (
      .CLK(clk), .RST(rst), .bus(if2.slave));

   // Clock and reset defaults.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic e, input logic v,
                        input logic [7:0] dd, input logic [7:0] s, input logic [7:0] c);
      rst = r; en = e; vin = v; d = dd; set_m = s; clr_m = c;
   endtask

   task automatic chk_main(input string tag, input logic [7:0] q, input logic vo, input logic [1:0] cnt);
      check_val({tag, ".q"},   32'(if0.Q),         32'(q));
      check_val({tag, ".v"},   32'(if0.VALID_OUT), 32'(vo));
      check_val({tag, ".cnt"}, 32'(if0.CNT),       32'(cnt));
   endtask

   task automatic chk_d1(input string tag, input logic [7:0] q, input logic vo, input logic cnt);
      check_val({tag, ".q"},   32'(if2.Q),         32'(q));
      check_val({tag, ".v"},   32'(if2.VALID_OUT), 32'(vo));
      check_val({tag, ".cnt"}, 32'(if2.CNT),       32'(cnt));
   endtask

   // Independent valid-bit shadow of the 3-stage instance, driven from the stimulus.
   always @(posedge clk) begin
      if (rst) ref_v <= 3'b000;
      else if (en) ref_v <= {ref_v[1:0], vin};
   end

   // Occupancy must always match the number of valid stages.
   always @(negedge clk) begin
      if (mon_en) begin
         check_val("cnt_inv", 32'(if0.CNT), 32'(ref_v[0]) + 32'(ref_v[1]) + 32'(ref_v[2]));
         check_val("vout_inv", 32'(if0.VALID_OUT), 32'(ref_v[2]));
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      mon_en   = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00);

      // Reset dominates live inputs.
      step();
      chk_main("rst1", 8'h00, 1'b0, 2'd0);
      chk_d1("rst1_d1", 8'h00, 1'b0, 1'b0);
      mon_en = 1'b1;
      step();
      chk_main("rst2", 8'h00, 1'b0, 2'd0);

      // Fill: latency of three edges, CNT holds at 3 on entry+exit.
      drive(1'b0, 1'b1, 1'b1, 8'hA5, 8'h00, 8'h00);
      step(); chk_main("fill1", 8'h00, 1'b0, 2'd1);
      d = 8'h3C;
      step(); chk_main("fill2", 8'h00, 1'b0, 2'd2);
      d = 8'h5A;
      step(); chk_main("fill3", 8'hA5, 1'b1, 2'd3);
      d = 8'h77;
      step(); chk_main("fill4", 8'h3C, 1'b1, 2'd3);

      // SET/CLR collision on stage 0: CLR wins in main, SET wins in the other.
      drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h0F, 8'h03);
      step(); chk_main("mask1", 8'h5A, 1'b1, 2'd3);
      check_val("mask_d1.q", 32'(if2.Q), 32'h0C);
      drive(1'b0, 1'b1, 1'b1, 8'h11, 8'h00, 8'h00);
      step(); chk_main("mask2", 8'h77, 1'b1, 2'd3);
      d = 8'h22;
      step(); chk_main("mask3", 8'h0C, 1'b1, 2'd3);
      check_val("mask3_setp.q", 32'(if1.Q), 32'h0F);

      // Stall with SET=80: tail frozen, stage-0 word 22 -> A2.
      drive(1'b0, 1'b0, 1'b1, 8'h99, 8'h80, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step(); chk_main("stall", 8'h0C, 1'b1, 2'd3);
      end
      drive(1'b0, 1'b1, 1'b1, 8'h33, 8'h00, 8'h00);
      step(); chk_main("resume1", 8'h11, 1'b1, 2'd3);
      d = 8'h44;
      step(); chk_main("resume2", 8'hA2, 1'b1, 2'd3);

      // Mid-flight reset drops everything, refill counts from 1.
      drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
      step(); chk_main("midrst", 8'h00, 1'b0, 2'd0);
      drive(1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 8'h00);
      step(); chk_main("refill1", 8'h00, 1'b0, 2'd1);
      d = 8'h66;
      step(); chk_main("refill2", 8'h00, 1'b0, 2'd2);
      d = 8'h77;
      step(); chk_main("refill3", 8'h55, 1'b1, 2'd3);

      // Drain with bubbles; CNT must stop at 0.
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      step(); chk_main("drain1", 8'h66, 1'b1, 2'd2);
      step(); chk_main("drain2", 8'h77, 1'b1, 2'd1);
      step(); chk_main("drain3", 8'h00, 1'b0, 2'd0);
      step(); chk_main("drain4", 8'h00, 1'b0, 2'd0);

      // Single-stage instance: masks reach Q during a stall.
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      step(); chk_d1("d1_rst", 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 8'hC3, 8'h00, 8'h00);
      step(); chk_d1("d1_load", 8'hC3, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 8'hC0);
      step(); chk_d1("d1_stall", 8'h07, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 8'hAA, 8'h00, 8'h00);
      step(); chk_d1("d1_bubble", 8'hAA, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 8'hBB, 8'h00, 8'h00);
      step(); chk_d1("d1_in", 8'hBB, 1'b1, 1'b1);
      d = 8'hCC;
      step(); chk_d1("d1_swap", 8'hCC, 1'b1, 1'b1);

      @(negedge clk);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
